// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the digit-serial add/sub unit.
// The FSM state encoding and default sizing live here.
package serial_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_DIGIT_W = 8;

endpackage

// File: rtl/serial_add_sub_unit_if.sv
// Request/response bundle of serial_add_sub_unit.
// Port ovf exists only when OVERFLOW_FLAG_EN is defined.
interface serial_add_sub_unit_if
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             a31;
   logic             b31;
   logic             carry;
   logic             zero;
   logic             diff;
`ifdef OVERFLOW_FLAG_EN
   logic             ovf;
`endif

   modport master (
      output start, sub, a, b,
`ifdef OVERFLOW_FLAG_EN
      input  ovf,
`endif
      input  busy, done, result,
      input  a31, b31, carry, zero, diff
   );

   modport slave (
      input  start, sub, a, b,
`ifdef OVERFLOW_FLAG_EN
      output ovf,
`endif
      output busy, done, result,
      output a31, b31, carry, zero, diff
   );

endinterface

// File: rtl/add_sub_digit.sv
// Combinational DIGIT_W-bit add/sub slice; also exposes the carry
// into its top bit so the caller can derive signed overflow.
module add_sub_digit #(
   parameter int DIGIT_W = 8
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   input  logic               inv,
   output logic [DIGIT_W-1:0] sum,
   output logic               cout,
   output logic               cmsb
);

   logic [DIGIT_W-1:0] bx;
   logic [DIGIT_W-1:0] low;
   logic [1:0]         top;

   assign bx = inv ? ~b : b;

   // low[DIGIT_W-1] is the carry into the top bit
   assign low = {1'b0, a[DIGIT_W-2:0]}
              + {1'b0, bx[DIGIT_W-2:0]}
              + {{(DIGIT_W-1){1'b0}}, cin};

   assign cmsb = low[DIGIT_W-1];

   assign top = {1'b0, a[DIGIT_W-1]}
              + {1'b0, bx[DIGIT_W-1]}
              + {1'b0, cmsb};

   assign sum  = {top[0], low[DIGIT_W-2:0]};
   assign cout = top[1];

endmodule

// File: rtl/serial_add_sub_unit.sv
// Digit-serial WIDTH-bit adder/subtractor with comparison flags.
// Optional signed-overflow output enabled by OVERFLOW_FLAG_EN.
module serial_add_sub_unit
   import serial_alu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DIGIT_W = DEF_DIGIT_W
) (
   input  logic clk,
   input  logic rst,
   serial_add_sub_unit_if.slave bus
);

   localparam int N     = WIDTH / DIGIT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             sub_q, sub_d;
   logic             cy_q, cy_d;
   logic             done_q, done_d;
   logic             a31_q, a31_d;
   logic             b31_q, b31_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             diff_q, diff_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT_W-1:0] dig_a;
   logic [DIGIT_W-1:0] dig_b;
   logic [DIGIT_W-1:0] dig_sum;
   logic               dig_cout;
`ifdef OVERFLOW_FLAG_EN
   logic               dig_cmsb;
`endif

   assign dig_a = a_q[idx_q*DIGIT_W +: DIGIT_W];
   assign dig_b = b_q[idx_q*DIGIT_W +: DIGIT_W];

   // one slice, reused for every digit position
   add_sub_digit #(
      .DIGIT_W (DIGIT_W)
   ) u_digit (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (cy_q),
      .inv  (sub_q == OP_SUB),
      .sum  (dig_sum),
      .cout (dig_cout),
`ifdef OVERFLOW_FLAG_EN
      .cmsb (dig_cmsb)
`else
      .cmsb ()
`endif
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      cy_d     = cy_q;
      result_d = result_q;
      done_d   = 1'b0;
      a31_d    = a31_q;
      b31_d    = b31_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      diff_d   = diff_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               sub_d   = bus.sub;
               cy_d    = bus.sub;
               a31_d   = bus.a[WIDTH-1];
               b31_d   = bus.b[WIDTH-1];
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            result_d[idx_q*DIGIT_W +: DIGIT_W] = dig_sum;
            cy_d  = dig_cout;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST) begin
               state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
               ovf_d = dig_cmsb ^ dig_cout;
`endif
            end
         end
         DONE: begin
            // flags are taken from the completed result register
            done_d  = 1'b1;
            carry_d = cy_q;
            zero_d  = (result_q == '0);
            diff_d  = result_q[WIDTH-1];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         cy_q     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         a31_q    <= 1'b0;
         b31_q    <= 1'b0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         diff_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         cy_q     <= cy_d;
         result_q <= result_d;
         done_q   <= done_d;
         a31_q    <= a31_d;
         b31_q    <= b31_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         diff_q   <= diff_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.a31    = a31_q;
   assign bus.b31    = b31_q;
   assign bus.carry  = carry_q;
   assign bus.zero   = zero_q;
   assign bus.diff   = diff_q;
`ifdef OVERFLOW_FLAG_EN
   assign bus.ovf    = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Bench for serial_add_sub_unit: vector table, random ops vs a
// plain-arithmetic model, and hand-written corner sequences.
module tb_serial_add_sub_unit;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_add_sub_unit_if #(.WIDTH(32)) bus ();

   serial_add_sub_unit #(
      .WIDTH   (32),
      .DIGIT_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        s;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] r;
      logic        c;
      logic        z;
      logic        d;
      logic        o;
   } vec_t;

   vec_t vecs[8];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model(input logic s, input logic [31:0] x, y,
                        output logic [31:0] r,
                        output logic c, z, d, o);
      logic [32:0] t;
      if (s) begin
         t = {1'b0, x} - {1'b0, y};
         c = (x >= y);
         o = (x[31] != y[31]) && (t[31] != x[31]);
      end else begin
         t = {1'b0, x} + {1'b0, y};
         c = t[32];
         o = (x[31] == y[31]) && (t[31] != x[31]);
      end
      r = t[31:0];
      z = (r == 32'd0);
      d = r[31];
   endtask

   // returns the number of edges from the start edge until done is seen
   task automatic do_op(input logic s, input logic [31:0] x, y,
                        output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = s;
      bus.a     = x;
      bus.b     = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.sub   = 1'($urandom);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_op(input string tg, input logic s,
                           input logic [31:0] x, y, r,
                           input logic c, z, d, o, input int lat);
      chk({tg, " latency"}, lat, 5);
      chk({tg, " result"}, bus.result, r);
      chk({tg, " carry"}, 32'(bus.carry), 32'(c));
      chk({tg, " zero"}, 32'(bus.zero), 32'(z));
      chk({tg, " diff"}, 32'(bus.diff), 32'(d));
      chk({tg, " a31"}, 32'(bus.a31), 32'(x[31]));
      chk({tg, " b31"}, 32'(bus.b31), 32'(y[31]));
`ifdef OVERFLOW_FLAG_EN
      chk({tg, " ovf"}, 32'(bus.ovf), 32'(o));
`else
      if (o === 1'bx || s === 1'bx) $display("note: x in model");
`endif
      @(posedge clk);
      #1;
      chk({tg, " done pulse width"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [31:0] er, hr;
      logic        ec, ez, ed, eo;
      logic [6:0]  hf;
      int          lat, ndone;

      vecs[0] = '{1'b1, 32'h5,        32'h5,        32'h0,        1, 1, 0, 0};
      vecs[1] = '{1'b1, 32'h3,        32'h5,        32'hFFFFFFFE, 0, 0, 1, 0};
      vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 1, 0, 0};
      vecs[3] = '{1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 0, 1, 1};
      vecs[4] = '{1'b1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1, 0, 0, 1};
      vecs[5] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, 0};
      vecs[6] = '{1'b1, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0};
      vecs[7] = '{1'b0, 32'h000000FF, 32'h1,        32'h00000100, 0, 0, 0, 0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = 32'hDEADBEEF;
      bus.b     = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset done", 32'(bus.done), 32'd0);
      chk("reset result", bus.result, 32'd0);
      chk("reset flags",
          {27'd0, bus.a31, bus.b31, bus.carry, bus.zero, bus.diff},
          32'd0);

      foreach (vecs[i]) begin
         do_op(vecs[i].s, vecs[i].x, vecs[i].y, lat);
         check_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].x,
                  vecs[i].y, vecs[i].r, vecs[i].c, vecs[i].z,
                  vecs[i].d, vecs[i].o, lat);
      end

      for (int i = 0; i < 40; i++) begin
         logic        s;
         logic [31:0] x, y;
         s = 1'($urandom);
         x = $urandom;
         y = (i % 8 == 0) ? x : $urandom;
         model(s, x, y, er, ec, ez, ed, eo);
         do_op(s, x, y, lat);
         check_op($sformatf("rand%0d", i), s, x, y, er, ec, ez, ed,
                  eo, lat);
      end

      // start pulses inside RUN and in DONE must be ignored
      model(1'b0, 32'h01020304, 32'h10203040, er, ec, ez, ed, eo);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.a     = 32'h01020304;
      bus.b     = 32'h10203040;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      ndone = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == 2 || cyc == 4) begin
            bus.start = 1'b1;
            bus.sub   = 1'b1;
            bus.a     = 32'hFFFF0000;
            bus.b     = 32'h0000FFFF;
         end else begin
            bus.start = 1'b0;
         end
         if (cyc <= 6)
            chk($sformatf("ign busy c%0d", cyc), 32'(bus.busy),
                32'(cyc <= 3));
         if (bus.done) begin
            ndone++;
            chk("ign done cycle", cyc, 5);
            chk("ign result", bus.result, er);
         end
      end
      chk("ign done count", ndone, 1);
      chk("ign result held", bus.result, er);

      // reset while digit 2 is being processed
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.a     = 32'h89ABCDEF;
      bus.b     = 32'h89ABCDEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst result", bus.result, 32'd0);
      chk("rst flags",
          {27'd0, bus.a31, bus.b31, bus.carry, bus.zero, bus.diff},
          32'd0);
`ifdef OVERFLOW_FLAG_EN
      chk("rst ovf", 32'(bus.ovf), 32'd0);
`endif
      ndone = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      chk("rst no done", ndone, 0);

      do_op(1'b1, 32'h10, 32'h01, lat);
      check_op("after rst", 1'b1, 32'h10, 32'h01, 32'h0000000F,
               1'b1, 1'b0, 1'b0, 1'b0, lat);

      // outputs hold while inputs toggle
      hr = 32'h0000000F;
      hf = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         bus.a   = ~bus.a;
         bus.b   = $urandom;
         bus.sub = ~bus.sub;
         chk($sformatf("hold result c%0d", cyc), bus.result, hr);
         chk($sformatf("hold flags c%0d", cyc),
             {25'd0, bus.a31, bus.b31, bus.carry, bus.zero,
              bus.diff, bus.busy, bus.done},
             {25'd0, hf});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
